multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style finite state machine that sequences the multi-cycle MIPS-subset datapath. It consumes the `op` field produced by the instruction decoder and drives every datapath strobe and select, one state per cycle. It holds memory-access states under a simple request/ready handshake, so one shared memory serves both instruction fetch and data access. It sits between the instruction register/decoder and the PC, register file, ALU and memory-port muxes.

## Interface
Parameters: none. Opcodes are fixed:
- R-type: `6'b000000`
- lw: `6'b100011`
- sw: `6'b101011`
- beq: `6'b000100`
- addi: `6'b001000`
- j: `6'b000010`

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  opcode from the decoder (instruction register bits [31:26])
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  access is a write (valid only with mem_req)
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- ir_write  out  1  load the instruction register
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update if ALU zero (beq)
- pc_src  out  2  PC source: 00 = ALU, 01 = ALU out register, 10 = jump target
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  ALU control: 00 = add, 01 = subtract, 10 = use funct
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-data select: 0 = ALU out, 1 = memory data register
- reg_write  out  1  register file write
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- trap  out  1  illegal-opcode trap flag (see Configuration)

## Operation
States and their assertions. Any signal not listed is 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. When mem_ready=1, also ir_write=1 and pc_write=1, and the next state is DECODE. Otherwise the FSM stays in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). Next state by op:
  - lw or sw -> MEMADR
  - R-type -> RTYPEEX
  - beq -> BEQEX
  - addi -> ADDIEX
  - j -> JEX
  - any other op -> ILLEGAL handling (see Configuration)
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Goes to MEMWB on mem_ready.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 -> FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. On mem_ready: instr_done=1 -> FETCH.
- RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTYPEWB.
- RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, instr_done=1 -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- JEX: pc_write=1, pc_src=10, instr_done=1 -> FETCH.

Handshake and sampling rules:
- While mem_req=1 and mem_ready=0, all outputs are held stable.
- An access completes in the cycle where mem_req and mem_ready are both 1.
- mem_ready is ignored in all other states.
- op is sampled only in DECODE and MEMADR; the instruction register is stable in both.

## Timing
- Outputs are decoded combinationally from the registered state, plus mem_ready in FETCH and MEMWR.
- While reset=1, all outputs are forced to 0. At the reset edge the state becomes FETCH (or trap clears).
- Reset asserted in any state, including mid-wait in MEMRD or MEMWR, returns the FSM to FETCH on the next edge. The access is abandoned and no strobe is issued.
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle (mem_ready=0 in a memory state) adds 1 cycle.
- instr_done asserts exactly once per instruction, in its last cycle.
- mem_ready=1 on the first cycle of a memory state gives zero wait.

## Configuration
- `ILLEGAL_OP_TRAP_EN` defined:
  - An unrecognised op in DECODE moves the FSM to state TRAP.
  - In TRAP, trap=1 and all other outputs are 0. The FSM remains in TRAP until reset.
  - instr_done is not asserted.
- `ILLEGAL_OP_TRAP_EN` undefined:
  - An unrecognised op is executed as a NOP: DECODE -> FETCH, with instr_done=1 in DECODE.
  - trap is tied to 0 and state TRAP does not exist.

## Test plan
- Reset held 3 cycles with mem_ready=1 -> all outputs 0 during reset; the first cycle after release is FETCH with mem_req=1, ir_write=1, pc_write=1.
- R-type (op=000000), mem_ready=1 -> FETCH, DECODE, RTYPEEX, RTYPEWB. reg_write=1 with reg_dst=1 in cycle 4; instr_done pulses in cycle 4 only.
- lw (op=100011), with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMRD -> 8 cycles total. ir_write pulses once; mem_to_reg=1 and reg_write=1 in the final cycle.
- beq (op=000100) -> cycle 3 shows alu_op=01, pc_write_cond=1, pc_src=01, instr_done=1. The next cycle is FETCH.
- op=111111 -> with `ILLEGAL_OP_TRAP_EN`: trap=1 from cycle 3 onward, held for 10 cycles, then cleared by reset. Without it: instr_done=1 in DECODE and FETCH in cycle 3.
- sw (op=101011) with reset asserted in MEMWR while mem_ready=0 -> mem_write never completes. The cycle after reset deasserts is FETCH with mem_write=0.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore control FSM for the multi-cycle MIPS-subset datapath with a
//            req/ready shared-memory handshake. Optional macro
//            ILLEGAL_OP_TRAP_EN parks unknown opcodes in a TRAP state.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       trap
);

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
        , TRAP  = 4'd12
`endif
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        trap          = 1'b0;

        case (r_state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = DECODE;
                end
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                alu_src_b = 2'b11;
                case (op)
                    c_op_lw, c_op_sw: w_next = MEMADR;
                    c_op_rtype:       w_next = RTYPEEX;
                    c_op_beq:         w_next = BEQEX;
                    c_op_addi:        w_next = ADDIEX;
                    c_op_j:           w_next = JEX;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        w_next = TRAP;
`else
                        instr_done = 1'b1;
                        w_next     = FETCH;
`endif
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op == c_op_sw) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    w_next = MEMWB;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                w_next     = FETCH;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = FETCH;
                end
            end
            RTYPEEX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = RTYPEWB;
            end
            RTYPEWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                w_next     = FETCH;
            end
            BEQEX: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                instr_done    = 1'b1;
                w_next        = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = FETCH;
            end
            JEX: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                w_next     = FETCH;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP: begin
                trap   = 1'b1;
                w_next = TRAP;
            end
`endif
            default: w_next = FETCH;
        endcase

        // Reset quiets every strobe so an abandoned access issues nothing
        if (reset) begin
            mem_req       = 1'b0;
            mem_write     = 1'b0;
            iord          = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_src        = 2'b00;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            instr_done    = 1'b0;
            trap          = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed self-checking bench for multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b000000;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, trap;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .instr_done(instr_done), .trap(trap)
    );

    always #5 clk = ~clk;

    // {mem_req,mem_write,iord,ir_write,pc_write,pc_write_cond,pc_src,
    //  alu_src_a,alu_src_b,alu_op,reg_dst,mem_to_reg,reg_write,instr_done,trap}
    logic [17:0] outs;
    assign outs = {mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond,
                   pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                   reg_write, instr_done, trap};

    localparam logic [17:0] E_ZERO    = 18'b0;
    localparam logic [17:0] E_FETCH_W = 18'b1_0_0_0_0_0_00_0_01_00_0_0_0_0_0;
    localparam logic [17:0] E_FETCH_R = 18'b1_0_0_1_1_0_00_0_01_00_0_0_0_0_0;
    localparam logic [17:0] E_DECODE  = 18'b0_0_0_0_0_0_00_0_11_00_0_0_0_0_0;
    localparam logic [17:0] E_DEC_NOP = 18'b0_0_0_0_0_0_00_0_11_00_0_0_0_1_0;
    localparam logic [17:0] E_MEMADR  = 18'b0_0_0_0_0_0_00_1_10_00_0_0_0_0_0;
    localparam logic [17:0] E_MEMRD   = 18'b1_0_1_0_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [17:0] E_MEMWB   = 18'b0_0_0_0_0_0_00_0_00_00_0_1_1_1_0;
    localparam logic [17:0] E_MEMWR_W = 18'b1_1_1_0_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [17:0] E_MEMWR_R = 18'b1_1_1_0_0_0_00_0_00_00_0_0_0_1_0;
    localparam logic [17:0] E_RTYPEEX = 18'b0_0_0_0_0_0_00_1_00_10_0_0_0_0_0;
    localparam logic [17:0] E_RTYPEWB = 18'b0_0_0_0_0_0_00_0_00_00_1_0_1_1_0;
    localparam logic [17:0] E_BEQEX   = 18'b0_0_0_0_0_1_01_1_00_01_0_0_0_1_0;
    localparam logic [17:0] E_ADDIWB  = 18'b0_0_0_0_0_0_00_0_00_00_0_0_1_1_0;
    localparam logic [17:0] E_JEX     = 18'b0_0_0_0_1_0_10_0_00_00_0_0_0_1_0;
    localparam logic [17:0] E_TRAP    = 18'b0_0_0_0_0_0_00_0_00_00_0_0_0_0_1;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first FETCH cycle after a one-cycle reset
    task automatic apply_reset(input logic [5:0] o);
        next_cycle();
        reset     = 1'b1;
        mem_ready = 1'b0;
        op        = o;
        next_cycle();
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            reset = 1'b1; mem_ready = 1'b1; #4;
            chk_cnt++;
            if (outs !== E_ZERO) $display("FAIL reset_cyc%0d got %b want %b", i, outs, E_ZERO);
            else pass_cnt++;
        end
        next_cycle();
        reset = 1'b0; mem_ready = 1'b1; #4;
        chk_cnt++;
        if (outs !== E_FETCH_R) $display("FAIL reset_release got %b want %b", outs, E_FETCH_R);
        else pass_cnt++;
    endtask

    task automatic test_rtype();
        logic [17:0] ev [5] = '{E_FETCH_R, E_DECODE, E_RTYPEEX, E_RTYPEWB, E_FETCH_R};
        int done_cnt = 0;
        apply_reset(6'b000000);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            mem_ready = 1'b1; #4;
            if (i < 4 && instr_done) done_cnt++;
            chk_cnt++;
            if (outs !== ev[i]) $display("FAIL rtype_cyc%0d got %b want %b", i + 1, outs, ev[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (done_cnt !== 1) $display("FAIL rtype_done_count got %0d want 1", done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_lw_waits();
        logic [17:0] ev [9] = '{E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE, E_MEMADR,
                                E_MEMRD, E_MEMRD, E_MEMWB, E_FETCH_R};
        logic        mr [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int ir_cnt = 0;
        apply_reset(6'b100011);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) next_cycle();
            mem_ready = mr[i]; #4;
            if (i < 8 && ir_write) ir_cnt++;
            chk_cnt++;
            if (outs !== ev[i]) $display("FAIL lw_cyc%0d got %b want %b", i + 1, outs, ev[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (ir_cnt !== 1) $display("FAIL lw_ir_write_count got %0d want 1", ir_cnt);
        else pass_cnt++;
    endtask

    task automatic test_sw();
        logic [17:0] ev [5] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR_R, E_FETCH_R};
        apply_reset(6'b101011);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            mem_ready = 1'b1; #4;
            chk_cnt++;
            if (outs !== ev[i]) $display("FAIL sw_cyc%0d got %b want %b", i + 1, outs, ev[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_sw_reset_midwait();
        logic [17:0] ev [6] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR_W, E_ZERO, E_FETCH_W};
        logic        mr [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        rs [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset(6'b101011);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            mem_ready = mr[i]; reset = rs[i]; #4;
            chk_cnt++;
            if (outs !== ev[i]) $display("FAIL sw_abort_cyc%0d got %b want %b", i + 1, outs, ev[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_beq_addi_j();
        logic [5:0]  ops [3]    = '{6'b000100, 6'b001000, 6'b000010};
        logic [17:0] ev  [3][5] = '{'{E_FETCH_R, E_DECODE, E_BEQEX,  E_FETCH_R, E_DECODE},
                                    '{E_FETCH_R, E_DECODE, E_MEMADR, E_ADDIWB,  E_FETCH_R},
                                    '{E_FETCH_R, E_DECODE, E_JEX,    E_FETCH_R, E_DECODE}};
        for (int t = 0; t < 3; t++) begin
            apply_reset(ops[t]);
            for (int i = 0; i < 5; i++) begin
                if (i > 0) next_cycle();
                mem_ready = 1'b1; #4;
                chk_cnt++;
                if (outs !== ev[t][i])
                    $display("FAIL op%b_cyc%0d got %b want %b", ops[t], i + 1, outs, ev[t][i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_illegal();
        apply_reset(6'b111111);
        mem_ready = 1'b1; #4;
        chk_cnt++;
        if (outs !== E_FETCH_R) $display("FAIL illegal_fetch got %b want %b", outs, E_FETCH_R);
        else pass_cnt++;
        next_cycle(); #4;
`ifdef ILLEGAL_OP_TRAP_EN
        chk_cnt++;
        if (outs !== E_DECODE) $display("FAIL illegal_decode got %b want %b", outs, E_DECODE);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            mem_ready = i[0]; #4;
            chk_cnt++;
            if (outs !== E_TRAP) $display("FAIL trap_hold_cyc%0d got %b want %b", i, outs, E_TRAP);
            else pass_cnt++;
        end
        next_cycle();
        reset = 1'b1; #4;
        chk_cnt++;
        if (outs !== E_ZERO) $display("FAIL trap_reset got %b want %b", outs, E_ZERO);
        else pass_cnt++;
        next_cycle();
        reset = 1'b0; mem_ready = 1'b1; #4;
        chk_cnt++;
        if (outs !== E_FETCH_R) $display("FAIL trap_exit got %b want %b", outs, E_FETCH_R);
        else pass_cnt++;
`else
        chk_cnt++;
        if (outs !== E_DEC_NOP) $display("FAIL nop_decode got %b want %b", outs, E_DEC_NOP);
        else pass_cnt++;
        next_cycle(); #4;
        chk_cnt++;
        if (outs !== E_FETCH_R) $display("FAIL nop_refetch got %b want %b", outs, E_FETCH_R);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_waits();
        test_sw();
        test_sw_reset_midwait();
        test_beq_addi_j();
        test_illegal();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
